// File: rtl/param_adder_acc.sv
// param_adder_acc: pipelined ADD/ACC/SAT/SUB adder-accumulator with valid/ready on both sides.
// Latency: LATENCY cycles from accept to result (stage 1 computes, LATENCY-1 delay stages).
// Backpressure: a held result with out_ready low freezes every stage and acc, and drops in_ready.
module param_adder_acc #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             tb_clk,
  input  logic             tb_rst,
  input  logic             enable,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             ovf,
  output logic             sum_valid,
  input  logic             out_ready
);

  localparam int RW = WIDTH + 1;
  localparam logic [RW-1:0] SAT_MAX = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_ACC = 2'b01,
    MODE_SAT = 2'b10,
    MODE_SUB = 2'b11
  } mode_t;

  // One pipeline slot: result, its flag and whether it carries an item.
  typedef struct packed {
    logic          vld;
    logic          ovf;
    logic [RW-1:0] sum;
  } stage_t;

  // pipe[0] is the compute stage, pipe[LATENCY-1] drives the outputs.
  stage_t [LATENCY-1:0] pipe;
  stage_t               s1_nxt;

  mode_t         mode_sel;
  logic          stall;
  logic          accept;
  logic          clr_pend;
  logic          clr_eff;
  logic [RW-1:0] acc;
  logic [RW-1:0] acc_base;
  logic [RW-1:0] acc_nxt;
  logic [RW:0]   acc_res;
  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] add_res;
  logic [RW-1:0] sub_res;

  // The whole pipe freezes only when the output holds an unconsumed result.
  assign stall     = pipe[LATENCY-1].vld && !out_ready;
  assign in_ready  = !stall;
  assign accept    = enable && in_ready;
  assign mode_sel  = mode_t'(mode);

  // A clear seen while stalled is remembered and applied on the first moving edge.
  assign clr_eff   = clr || clr_pend;

  assign sum       = pipe[LATENCY-1].sum;
  assign ovf       = pipe[LATENCY-1].ovf;
  assign sum_valid = pipe[LATENCY-1].vld;

  // Shared arithmetic at full WIDTH+1 width; clear is applied before the ACC add.
  always_comb begin
    a_ext    = {1'b0, a};
    b_ext    = {1'b0, b};
    add_res  = a_ext + b_ext;
    sub_res  = a_ext - b_ext;
    acc_base = clr_eff ? '0 : acc;
    acc_res  = {1'b0, acc_base} + {1'b0, a_ext};
  end

  // Stage-1 result select by mode.
  always_comb begin
    s1_nxt     = '0;
    s1_nxt.vld = accept;
    case (mode_sel)
      MODE_ADD: begin
        s1_nxt.sum = add_res;
        s1_nxt.ovf = 1'b0;
      end
      MODE_ACC: begin
        s1_nxt.sum = acc_res[RW-1:0];
        s1_nxt.ovf = acc_res[RW];
      end
      MODE_SAT: begin
        if (add_res[WIDTH]) begin
          s1_nxt.sum = SAT_MAX;
          s1_nxt.ovf = 1'b1;
        end else begin
          s1_nxt.sum = add_res;
          s1_nxt.ovf = 1'b0;
        end
      end
      default: begin
        s1_nxt.sum = sub_res;
        s1_nxt.ovf = (a < b);
      end
    endcase
  end

  // Accumulator moves only on an accepted ACC item; a pending clear still zeroes it otherwise.
  always_comb begin
    acc_nxt = acc_base;
    if (accept && (mode_sel == MODE_ACC)) begin
      acc_nxt = acc_res[RW-1:0];
    end
  end

  // Accumulator and deferred-clear state; both hold while stalled except for latching clr.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      acc      <= '0;
      clr_pend <= 1'b0;
    end else if (stall) begin
      if (clr) begin
        clr_pend <= 1'b1;
      end
    end else begin
      acc      <= acc_nxt;
      clr_pend <= 1'b0;
    end
  end

  // Pipeline shift: valids always advance when unstalled, data loads only behind a valid item.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      pipe <= '0;
    end else if (!stall) begin
      pipe[0].vld <= s1_nxt.vld;
      if (s1_nxt.vld) begin
        pipe[0].sum <= s1_nxt.sum;
        pipe[0].ovf <= s1_nxt.ovf;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i].vld <= pipe[i-1].vld;
        if (pipe[i-1].vld) begin
          pipe[i].sum <= pipe[i-1].sum;
          pipe[i].ovf <= pipe[i-1].ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_adder_acc.sv
// Bench for param_adder_acc: LATENCY=2 and LATENCY=1 instances share stimulus, one is observed.
// Reference is a time-stamped result queue plus an integer accumulator.
// Directed spec scenarios first, then randomized traffic with random backpressure.
module tb_param_adder_acc;

  localparam int W    = 4;
  localparam int MOD  = 1 << (W + 1);
  localparam int MAXV = (1 << W) - 1;

  logic         tb_clk    = 1'b0;
  logic         tb_rst    = 1'b0;
  logic         enable    = 1'b0;
  logic         clr       = 1'b0;
  logic         out_ready = 1'b1;
  logic [1:0]   mode      = 2'd0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;

  logic         in_ready_l2, in_ready_l1;
  logic         ovf_l2, ovf_l1;
  logic         sum_valid_l2, sum_valid_l1;
  logic [W:0]   sum_l2, sum_l1;

  int           lat = 2;
  logic         dut_in_ready, dut_ovf, dut_sum_valid;
  logic [W:0]   dut_sum;

  typedef struct {
    int sum;
    int ovf;
    int ready;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] got_sum[$];
  logic [31:0] got_ovf[$];
  int          acc_m      = 0;
  bit          clr_pend_m = 1'b0;
  int          cyc        = 0;
  int          checks     = 0;
  int          failures   = 0;

  always #5 tb_clk = ~tb_clk;

  param_adder_acc #(.WIDTH(W), .LATENCY(2)) dut_l2 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .enable(enable), .in_ready(in_ready_l2),
    .mode(mode), .clr(clr), .a(a), .b(b), .sum(sum_l2), .ovf(ovf_l2),
    .sum_valid(sum_valid_l2), .out_ready(out_ready)
  );

  param_adder_acc #(.WIDTH(W), .LATENCY(1)) dut_l1 (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .enable(enable), .in_ready(in_ready_l1),
    .mode(mode), .clr(clr), .a(a), .b(b), .sum(sum_l1), .ovf(ovf_l1),
    .sum_valid(sum_valid_l1), .out_ready(out_ready)
  );

  assign dut_in_ready  = (lat == 2) ? in_ready_l2  : in_ready_l1;
  assign dut_ovf       = (lat == 2) ? ovf_l2       : ovf_l1;
  assign dut_sum_valid = (lat == 2) ? sum_valid_l2 : sum_valid_l1;
  assign dut_sum       = (lat == 2) ? sum_l2       : sum_l1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s lat=%0d observed=%0d expected=%0d", tag, lat, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the reference at the rising edge.
  task automatic step(output bit accepted);
    bit    vld_e, stall_e, eff;
    int    s, o, t;
    item_t it;
    @(negedge tb_clk);
    vld_e   = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
    stall_e = vld_e && !out_ready;
    chk("sum_valid", dut_sum_valid, vld_e);
    chk("in_ready", dut_in_ready, !stall_e);
    if (vld_e) begin
      chk("sum", dut_sum, exp_q[0].sum);
      chk("ovf", dut_ovf, exp_q[0].ovf);
    end
    if (vld_e && out_ready) begin
      got_sum.push_back(dut_sum);
      got_ovf.push_back(dut_ovf);
    end
    @(posedge tb_clk);
    cyc++;
    accepted = 1'b0;
    if (stall_e) begin
      foreach (exp_q[i]) exp_q[i].ready++;
      if (clr) clr_pend_m = 1'b1;
    end else begin
      if (vld_e) it = exp_q.pop_front();
      eff        = clr || clr_pend_m;
      clr_pend_m = 1'b0;
      if (enable) begin
        accepted = 1'b1;
        s = 0;
        o = 0;
        case (mode)
          2'd0: s = int'(a) + int'(b);
          2'd1: begin
            t     = (eff ? 0 : acc_m) + int'(a);
            s     = t % MOD;
            o     = (t >= MOD) ? 1 : 0;
            acc_m = s;
          end
          2'd2: begin
            t = int'(a) + int'(b);
            if (t > MAXV) begin
              s = MAXV;
              o = 1;
            end else begin
              s = t;
            end
          end
          default: begin
            s = (int'(a) - int'(b) + MOD) % MOD;
            o = (a < b) ? 1 : 0;
          end
        endcase
        if (mode != 2'd1 && eff) acc_m = 0;
        it.sum   = s;
        it.ovf   = o;
        it.ready = cyc + lat - 1;
        exp_q.push_back(it);
      end else if (eff) begin
        acc_m = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit got;
    enable = 1'b0;
    clr    = 1'b0;
    for (int k = 0; k < n; k++) step(got);
  endtask

  task automatic send(input logic [1:0] m, input int x, input int y, input logic c);
    bit got;
    enable = 1'b1;
    mode   = m;
    a      = W'(x);
    b      = W'(y);
    clr    = c;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) step(got);
    checks++;
    assert (got)
    else begin
      failures++;
      $error("FAIL send_timeout lat=%0d observed=not_accepted expected=accepted", lat);
    end
    enable = 1'b0;
    clr    = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    tb_rst = 1'b1;
    #1;
    chk("rst_sum", dut_sum, 0);
    chk("rst_ovf", dut_ovf, 0);
    chk("rst_sum_valid", dut_sum_valid, 0);
    exp_q.delete();
    acc_m      = 0;
    clr_pend_m = 1'b0;
    enable     = 1'b0;
    clr        = 1'b0;
    @(posedge tb_clk);
    @(posedge tb_clk);
    #1;
    tb_rst = 1'b0;
  endtask

  task automatic check_tail(input string tag, input int n0, input int sums[], input int ovfs[]);
    chk({tag, "_count"}, got_sum.size() - n0, sums.size());
    for (int i = 0; i < sums.size() && (n0 + i) < got_sum.size(); i++) begin
      chk({tag, "_sum"}, got_sum[n0 + i], sums[i]);
      chk({tag, "_ovf"}, got_ovf[n0 + i], ovfs[i]);
    end
  endtask

  task automatic test_add();
    int n0 = got_sum.size();
    send(2'd0, 15, 15, 1'b0);
    idle(3);
    check_tail("add", n0, '{30}, '{0});
  endtask

  task automatic test_acc();
    bit got;
    int n0;
    enable = 1'b0;
    clr    = 1'b1;
    step(got);
    clr = 1'b0;
    n0  = got_sum.size();
    for (int k = 0; k < 4; k++) send(2'd1, 9, 0, 1'b0);
    idle(3);
    check_tail("acc", n0, '{9, 18, 27, 4}, '{0, 0, 0, 1});
  endtask

  task automatic test_sat_sub();
    int n0 = got_sum.size();
    send(2'd2, 12, 7, 1'b0);
    send(2'd2, 3, 4, 1'b0);
    send(2'd1, 0, 0, 1'b0);
    idle(3);
    check_tail("sat", n0, '{15, 7, 4}, '{1, 0, 0});
    n0 = got_sum.size();
    send(2'd3, 3, 5, 1'b0);
    send(2'd3, 9, 2, 1'b0);
    idle(3);
    check_tail("sub", n0, '{30, 7}, '{1, 0});
  endtask

  task automatic test_backpressure();
    bit got;
    int nacc = 0;
    int n0   = got_sum.size();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      enable = 1'b1;
      mode   = 2'd0;
      clr    = 1'b0;
      a      = W'(nacc + 1);
      b      = W'(nacc + 1);
      step(got);
      if (got) nacc++;
    end
    chk("bp_held", nacc, lat);
    chk("bp_in_ready", dut_in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && nacc < 3; k++) begin
      enable = 1'b1;
      a      = W'(nacc + 1);
      b      = W'(nacc + 1);
      step(got);
      if (got) nacc++;
    end
    idle(4);
    check_tail("bp", n0, '{2, 4, 6}, '{0, 0, 0});
  endtask

  task automatic random_run(input int n);
    bit got = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (!enable || got) begin
        enable = ($urandom_range(0, 3) != 0);
        mode   = 2'($urandom_range(0, 3));
        a      = W'($urandom);
        b      = W'($urandom);
      end
      clr       = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step(got);
    end
    out_ready = 1'b1;
    idle(5);
  endtask

  initial begin
    #1;
    tb_rst = 1'b1;
    #1;
    chk("init_sum", dut_sum, 0);
    chk("init_ovf", dut_ovf, 0);
    chk("init_sum_valid", dut_sum_valid, 0);
    @(posedge tb_clk);
    @(posedge tb_clk);
    #1;
    tb_rst = 1'b0;

    // LATENCY=2: reset with two items in flight, then the directed scenarios.
    lat = 2;
    begin
      int n0;
      send(2'd0, 1, 2, 1'b0);
      send(2'd0, 3, 4, 1'b0);
      do_reset();
      n0 = got_sum.size();
      send(2'd0, 5, 5, 1'b0);
      idle(3);
      check_tail("post_rst", n0, '{10}, '{0});
    end
    test_add();
    test_acc();
    test_sat_sub();
    test_backpressure();
    random_run(300);

    // LATENCY=1 rerun on the second instance.
    lat = 1;
    do_reset();
    test_add();
    test_acc();
    test_sat_sub();
    test_backpressure();
    random_run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog lat=%0d observed=running expected=finished", lat);
    $fatal(1, "watchdog expired");
  end

endmodule
